// File: rtl/fetch_unit.sv
// Fetch/PC stage: drives instruction address, resolves branches against ALU flags, sequences start/halt.
// Decode is combinational from instr_in; PC is registered and a stall freezes PC, state and branch evaluation.
module fetch_unit #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               start,
  input  logic [PC_W-1:0]    start_addr,
  input  logic               stall,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               flag_we,
  input  logic               z_in,
  input  logic               n_in,
  output logic [PC_W-1:0]    pc_out,
  output logic               instr_valid,
  output logic [4:0]         op_out,
  output logic               done
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic            z_flag;
  logic            n_flag;

  logic [3:0]      opcode;
  logic [4:0]      operand;
  logic [PC_W-1:0] offset;
  logic [PC_W-1:0] next_pc;
  logic            taken;
  logic            is_halt;

  assign opcode  = instr_in[INSTR_W-1 -: 4];
  assign operand = instr_in[4:0];
  assign offset  = {{(PC_W-5){operand[4]}}, operand};
  assign is_halt = (opcode == 4'b1010) && (operand == 5'd0);

  // Branches see only the registered flags, never this cycle's ALU write-back.
  always_comb begin
    taken = 1'b0;
    case (opcode)
      4'b1010: taken = 1'b1;
      4'b1011: taken = !z_flag;
      4'b1100: taken = z_flag;
      4'b1101: taken = !n_flag;
      4'b1110: taken = !n_flag && !z_flag;
      4'b1111: taken = n_flag;
      default: taken = 1'b0;
    endcase
  end

  assign next_pc = taken ? (pc + offset) : (pc + PC_W'(1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      pc     <= '0;
      z_flag <= 1'b0;
      n_flag <= 1'b0;
    end else begin
      if (flag_we) begin
        z_flag <= z_in;
        n_flag <= n_in;
      end
      if (start) begin
        state <= RUN;
        pc    <= start_addr;
      end else if (state == RUN && !stall) begin
        if (is_halt) state <= HALT;
        else         pc    <= next_pc;
      end
    end
  end

  assign pc_out      = pc;
  assign instr_valid = (state == RUN) && !stall;
  assign op_out      = instr_valid ? {1'b0, opcode} : 5'd0;
  assign done        = (state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: branch vector table plus start/stall/halt/reset sequences.
module tb_fetch_unit;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] start_addr = '0;
  logic       stall = 1'b0;
  logic [8:0] instr_in;
  logic       flag_we = 1'b0;
  logic       z_in = 1'b0;
  logic       n_in = 1'b0;
  logic [9:0] pc_out;
  logic       instr_valid;
  logic [4:0] op_out;
  logic       done;

  logic [8:0] rom [0:1023];
  assign instr_in = rom[pc_out];

  fetch_unit #(.PC_W(10), .INSTR_W(9)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .start_addr(start_addr),
    .stall(stall), .instr_in(instr_in), .flag_we(flag_we), .z_in(z_in), .n_in(n_in),
    .pc_out(pc_out), .instr_valid(instr_valid), .op_out(op_out), .done(done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [9:0] pc;
    logic       valid;
    logic [4:0] op;
    logic       done;
  } obs_t;

  typedef struct {
    logic [9:0] addr;
    logic [3:0] op;
    logic [4:0] opd;
    logic       z;
    logic       n;
    logic [9:0] exp_pc;
    logic       exp_done;
  } vec_t;

  obs_t exp_q [$];
  vec_t vq [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] op_at(input logic [9:0] a);
    logic [8:0] w;
    w = rom[a];
    return {1'b0, w[8:5]};
  endfunction

  function automatic obs_t run_obs(input logic [9:0] a);
    obs_t o;
    o.pc = a; o.valid = 1'b1; o.op = op_at(a); o.done = 1'b0;
    return o;
  endfunction

  function automatic obs_t quiet_obs(input logic [9:0] a, input logic d);
    obs_t o;
    o.pc = a; o.valid = 1'b0; o.op = 5'd0; o.done = d;
    return o;
  endfunction

  // One clock; observed outputs are compared against the oldest queued expectation.
  task automatic tick();
    obs_t e;
    @(posedge Clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pc_out", 32'(pc_out), 32'(e.pc));
      check("instr_valid", 32'(instr_valid), 32'(e.valid));
      check("op_out", 32'(op_out), 32'(e.op));
      check("done", 32'(done), 32'(e.done));
    end
  endtask

  task automatic run_vec(input vec_t v);
    flag_we = 1'b1; z_in = v.z; n_in = v.n; start = 1'b0; stall = 1'b0;
    tick();
    flag_we = 1'b0;
    rom[v.addr] = {v.op, v.opd};
    start = 1'b1; start_addr = v.addr;
    exp_q.push_back(run_obs(v.addr));
    tick();
    start = 1'b0;
    if (v.exp_done) exp_q.push_back(quiet_obs(v.exp_pc, 1'b1));
    else            exp_q.push_back(run_obs(v.exp_pc));
    tick();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 9'd0;

    #3;
    check("reset_pc", 32'(pc_out), 32'h0);
    check("reset_valid", 32'(instr_valid), 32'h0);
    check("reset_op", 32'(op_out), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    #4 Reset_n = 1'b1;

    // Straight-line kadd run from 0x010
    for (int i = 0; i < 4; i++) rom[10'h010 + i] = {4'b0100, 5'd0};
    @(posedge Clk); #1;
    start = 1'b1; start_addr = 10'h010;
    exp_q.push_back(run_obs(10'h010));
    tick();
    start = 1'b0;
    for (int i = 1; i < 4; i++) begin
      exp_q.push_back(run_obs(10'h010 + 10'(i)));
      tick();
    end

    vq.push_back('{10'h010, 4'b0100, 5'd0,     1'b0, 1'b0, 10'h011, 1'b0});
    vq.push_back('{10'h020, 4'b1100, 5'd5,     1'b1, 1'b0, 10'h025, 1'b0});
    vq.push_back('{10'h020, 4'b1100, 5'd5,     1'b0, 1'b0, 10'h021, 1'b0});
    vq.push_back('{10'h005, 4'b1111, 5'b10000, 1'b0, 1'b1, 10'h3F5, 1'b0});
    vq.push_back('{10'h005, 4'b1111, 5'b10000, 1'b0, 1'b0, 10'h006, 1'b0});
    vq.push_back('{10'h3FF, 4'b0100, 5'd0,     1'b0, 1'b0, 10'h000, 1'b0});
    vq.push_back('{10'h100, 4'b1010, 5'd3,     1'b1, 1'b1, 10'h103, 1'b0});
    vq.push_back('{10'h050, 4'b1011, 5'b11110, 1'b0, 1'b0, 10'h04E, 1'b0});
    vq.push_back('{10'h050, 4'b1011, 5'b11110, 1'b1, 1'b0, 10'h051, 1'b0});
    vq.push_back('{10'h060, 4'b1101, 5'd7,     1'b1, 1'b0, 10'h067, 1'b0});
    vq.push_back('{10'h060, 4'b1101, 5'd7,     1'b0, 1'b1, 10'h061, 1'b0});
    vq.push_back('{10'h070, 4'b1110, 5'd4,     1'b0, 1'b0, 10'h074, 1'b0});
    vq.push_back('{10'h070, 4'b1110, 5'd4,     1'b1, 1'b0, 10'h071, 1'b0});
    vq.push_back('{10'h070, 4'b1110, 5'd4,     1'b0, 1'b1, 10'h071, 1'b0});
    vq.push_back('{10'h007, 4'b1010, 5'd0,     1'b0, 1'b0, 10'h007, 1'b1});
    vq.push_back('{10'h000, 4'b1010, 5'b11111, 1'b0, 1'b0, 10'h3FF, 1'b0});
    for (int i = 0; i < vq.size(); i++) run_vec(vq[i]);

    // Flag write in the same cycle as kbgt: old flags decide, new flags next cycle
    flag_we = 1'b1; z_in = 1'b0; n_in = 1'b0;
    tick();
    flag_we = 1'b0;
    rom[10'h040] = {4'b1110, 5'd4};
    rom[10'h044] = {4'b1110, 5'd4};
    rom[10'h045] = {4'b0100, 5'd0};
    start = 1'b1; start_addr = 10'h040;
    exp_q.push_back(run_obs(10'h040));
    tick();
    start = 1'b0; flag_we = 1'b1; z_in = 1'b1;
    exp_q.push_back(run_obs(10'h044));
    tick();
    flag_we = 1'b0;
    exp_q.push_back(run_obs(10'h045));
    tick();

    // Three-cycle stall at 0x030
    rom[10'h030] = {4'b0100, 5'd0};
    rom[10'h031] = {4'b0100, 5'd0};
    start = 1'b1; start_addr = 10'h030;
    exp_q.push_back(run_obs(10'h030));
    tick();
    start = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(quiet_obs(10'h030, 1'b0));
      tick();
    end
    stall = 1'b0;
    exp_q.push_back(run_obs(10'h031));
    tick();

    // start wins over stall
    start = 1'b1; stall = 1'b1; start_addr = 10'h200;
    exp_q.push_back(quiet_obs(10'h200, 1'b0));
    tick();
    start = 1'b0; stall = 1'b0;
    exp_q.push_back(run_obs(10'h201));
    tick();

    // Halt, hold, restart, then asynchronous reset mid-run
    rom[10'h007] = {4'b1010, 5'd0};
    rom[10'h100] = {4'b0100, 5'd0};
    rom[10'h101] = {4'b0100, 5'd0};
    start = 1'b1; start_addr = 10'h007;
    exp_q.push_back(run_obs(10'h007));
    tick();
    start = 1'b0;
    exp_q.push_back(quiet_obs(10'h007, 1'b1));
    tick();
    exp_q.push_back(quiet_obs(10'h007, 1'b1));
    tick();
    start = 1'b1; start_addr = 10'h100;
    exp_q.push_back(run_obs(10'h100));
    tick();
    start = 1'b0;
    exp_q.push_back(run_obs(10'h101));
    tick();
    #2 Reset_n = 1'b0;
    #1;
    check("async_reset_pc", 32'(pc_out), 32'h0);
    check("async_reset_done", 32'(done), 32'h0);
    check("async_reset_valid", 32'(instr_valid), 32'h0);
    tick();
    check("reset_held_pc", 32'(pc_out), 32'h0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
